// File: rtl/eq_pkg.sv
// eq_pkg: sample width, scheduler state encoding and output format,
// shared with the filter bank. SIGNED_OUT_EN selects two's complement output.
package eq_pkg;

   localparam int SAMPLE_W = 12;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      ARM  = 2'd2
   } sched_state_e;

   // Offset-binary to two's complement is a flip of the MSB.
   function automatic logic [SAMPLE_W-1:0] fmt_sample(
      input logic [SAMPLE_W-1:0] d
   );
`ifdef SIGNED_OUT_EN
      return {~d[SAMPLE_W-1], d[SAMPLE_W-2:0]};
`else
      return d;
`endif
   endfunction

endpackage

// File: rtl/sample_period_timer.sv
// sample_period_timer: 16-bit wrap counter 0..PERIOD-1, tick on last count.
// Ports: clk, rst (async active-low), clear (hold at 0), tick.
module sample_period_timer #(
   parameter int PERIOD = 64
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   output logic tick
);

   localparam logic [15:0] LAST = 16'(PERIOD - 1);

   logic [15:0] cnt_q;
   logic [15:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q + 16'd1;
      if (clear || cnt_q == LAST) begin
         cnt_d = '0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tick = !clear && (cnt_q == LAST);

endmodule

// File: rtl/adc_sample_scheduler.sv
// adc_sample_scheduler: opens one ADC window per PERIOD, captures the frame,
// hands it out over valid/ready; sticky overrun/timeout flags.
// Ports: clk, rst (async active-low), run, adc_rx_done, adc_data, adc_en,
//   sample_out/valid/ready, overrun, timeout, clr_flags, busy.
// Build option: SIGNED_OUT_EN (two's complement sample_out).
module adc_sample_scheduler
   import eq_pkg::*;
#(
   parameter int PERIOD  = 64,
   parameter int TIMEOUT = 32
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                run,
   input  logic                adc_rx_done,
   input  logic [SAMPLE_W-1:0] adc_data,
   output logic                adc_en,
   output logic [SAMPLE_W-1:0] sample_out,
   output logic                sample_valid,
   input  logic                sample_ready,
   output logic                overrun,
   output logic                timeout,
   input  logic                clr_flags,
   output logic                busy
);

   localparam logic [7:0] TLAST = 8'(TIMEOUT - 1);

   sched_state_e        state_q, state_d;
   logic [7:0]          tcnt_q, tcnt_d;
   logic [SAMPLE_W-1:0] sample_q, sample_d;
   logic                valid_q, valid_d;
   logic                ovr_q, ovr_d;
   logic                to_q, to_d;
   logic                tick;
   logic                capture;
   logic                expire;

   sample_period_timer #(
      .PERIOD (PERIOD)
   ) u_timer (
      .clk   (clk),
      .rst   (rst),
      .clear (!run),
      .tick  (tick)
   );

   // Ticks seen in ARM are ignored; the timer keeps free-running.
   always_comb begin
      state_d = state_q;
      tcnt_d  = tcnt_q;
      capture = 1'b0;
      expire  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (run) state_d = WAIT;
         end
         WAIT: begin
            if (!run) begin
               state_d = IDLE;
            end else if (tick) begin
               state_d = ARM;
               tcnt_d  = '0;
            end
         end
         ARM: begin
            if (!run) begin
               state_d = IDLE;
            end else if (adc_rx_done) begin
               capture = 1'b1;
               state_d = WAIT;
            end else if (tcnt_q == TLAST) begin
               expire  = 1'b1;
               state_d = WAIT;
            end else begin
               tcnt_d = tcnt_q + 8'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // A capture always wins over a consume, so valid stays set.
   always_comb begin
      sample_d = sample_q;
      if (capture) sample_d = fmt_sample(adc_data);
      valid_d = capture | (valid_q & ~sample_ready);
      ovr_d   = ovr_q | (capture & valid_q & ~sample_ready);
      to_d    = to_q | expire;
      if (clr_flags) begin
         ovr_d = 1'b0;
         to_d  = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= IDLE;
         tcnt_q   <= '0;
         sample_q <= '0;
         valid_q  <= 1'b0;
         ovr_q    <= 1'b0;
         to_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         tcnt_q   <= tcnt_d;
         sample_q <= sample_d;
         valid_q  <= valid_d;
         ovr_q    <= ovr_d;
         to_q     <= to_d;
      end
   end

   assign adc_en       = (state_q == ARM);
   assign busy         = (state_q == ARM);
   assign sample_out   = sample_q;
   assign sample_valid = valid_q;
   assign overrun      = ovr_q;
   assign timeout      = to_q;

endmodule

// File: tb/tb_adc_sample_scheduler.sv
// tb_adc_sample_scheduler: directed + randomized bench with an ADC model
// and a behavioural reference for windows, handshake and flags.
module tb_adc_sample_scheduler;

   localparam int P  = 64;
   localparam int TO = 32;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        run = 1'b0;
   logic        adc_rx_done = 1'b0;
   logic [11:0] adc_data = '0;
   logic        sample_ready = 1'b0;
   logic        clr_flags = 1'b0;
   logic        adc_en;
   logic [11:0] sample_out;
   logic        sample_valid;
   logic        overrun;
   logic        timeout;
   logic        busy;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int e0    = 0;
   int nk    = 1;

   logic        m_valid = 1'b0;
   logic [11:0] m_sample = '0;
   logic        m_ovr = 1'b0;
   logic        m_to = 1'b0;

   always #5 clk = ~clk;

   adc_sample_scheduler #(
      .PERIOD  (P),
      .TIMEOUT (TO)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .run          (run),
      .adc_rx_done  (adc_rx_done),
      .adc_data     (adc_data),
      .adc_en       (adc_en),
      .sample_out   (sample_out),
      .sample_valid (sample_valid),
      .sample_ready (sample_ready),
      .overrun      (overrun),
      .timeout      (timeout),
      .clr_flags    (clr_flags),
      .busy         (busy)
   );

   function automatic logic [11:0] fmt(input logic [11:0] d);
`ifdef SIGNED_OUT_EN
      return {~d[11], d[10:0]};
`else
      return d;
`endif
   endfunction

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      cyc++;
      #1;
   endtask

   // One clock with the reference applied to the inputs seen at that edge.
   task automatic step(input bit cap,
                       input logic [11:0] d,
                       input bit expd);
      if (cap) begin
         if (m_valid && !sample_ready) m_ovr = 1'b1;
         m_sample = fmt(d);
         m_valid  = 1'b1;
      end else if (m_valid && sample_ready) begin
         m_valid = 1'b0;
      end
      if (expd) m_to = 1'b1;
      if (clr_flags) begin
         m_ovr = 1'b0;
         m_to  = 1'b0;
      end
      tick();
      chk("valid", sample_valid, m_valid);
      chk("ovr", overrun, m_ovr);
      chk("tmo", timeout, m_to);
      if (m_valid) chk("data", sample_out, m_sample);
   endtask

   task automatic wait_arm();
      int n;
      n = 0;
      while (adc_en !== 1'b1 && n < P + 8) begin
         step(0, '0, 0);
         n++;
      end
      chk("arm_seen", adc_en, 1);
      chk("arm_time", cyc, e0 + nk * P - 1);
      chk("busy", busy, 1);
      nk++;
   endtask

   // Continue an open window: rx_done after d idle cycles (d>=TO: never).
   task automatic finish_frame(input int d,
                               input logic [11:0] data,
                               input logic rdy_cap);
      int hi;
      hi = 0;
      for (int j = 0; j < TO; j++) begin
         if (adc_en === 1'b1) hi++;
         if (j == d) begin
            sample_ready = rdy_cap;
            adc_rx_done  = 1'b1;
            adc_data     = data;
            step(1, data, 0);
            adc_rx_done  = 1'b0;
            adc_data     = $urandom();
            chk("cap_en", hi, d + 1);
            break;
         end else if (j == TO - 1) begin
            sample_ready = rdy_cap;
            step(0, '0, 1);
            chk("to_en", hi, TO);
         end else begin
            step(0, '0, 0);
         end
      end
      chk("en_low", adc_en, 0);
      chk("busy_low", busy, 0);
   endtask

   task automatic frame(input int d,
                        input logic [11:0] data,
                        input logic rdy_wait,
                        input logic rdy_cap);
      sample_ready = rdy_wait;
      wait_arm();
      finish_frame(d, data, rdy_cap);
   endtask

   task automatic pulse_clr();
      clr_flags = 1'b1;
      step(0, '0, 0);
      clr_flags = 1'b0;
   endtask

   initial begin
      // reset state
      #12;
      chk("rst_en", adc_en, 0);
      chk("rst_out", sample_out, 0);
      chk("rst_val", sample_valid, 0);
      chk("rst_flags", {overrun, timeout, busy}, 0);
      tick();
      rst = 1'b1;
      step(0, '0, 0);
      step(0, '0, 0);
      chk("idle_en", adc_en, 0);

      // T1: periodic captures at 17 cycles, ready high
      run = 1'b1;
      e0  = cyc + 1;
      nk  = 1;
      for (int i = 0; i < 3; i++) frame(17, 12'hA5C, 1, 1);
      chk("t1_out", sample_out, fmt(12'hA5C));

      // T2: two captures with ready low -> overrun
      frame(5, 12'h111, 1, 0);
      frame(9, 12'h222, 0, 0);
      chk("t2_ovr", overrun, 1);
      chk("t2_out", sample_out, fmt(12'h222));
      pulse_clr();
      chk("t2_clr", overrun, 0);
      sample_ready = 1'b1;
      step(0, '0, 0);

      // T3: ADC never answers
      frame(TO + 4, '0, 1, 1);
      chk("t3_to", timeout, 1);
      chk("t3_val", sample_valid, 0);
      pulse_clr();

      // T4: capture and consume in the same cycle
      frame(3, 12'h0C3, 1, 0);
      frame(11, 12'h800, 0, 1);
      chk("t4_val", sample_valid, 1);
      chk("t4_ovr", overrun, 0);
      chk("t4_out", sample_out, fmt(12'h800));

      // randomized frames
      for (int i = 0; i < 12; i++) begin
         frame($urandom_range(0, TO + 6), 12'($urandom()),
               1'($urandom()), 1'($urandom()));
      end
      pulse_clr();

      // T5: run dropped mid-ARM with a pending sample
      frame(2, 12'h3F0, 1, 0);
      wait_arm();
      step(0, '0, 0);
      step(0, '0, 0);
      run = 1'b0;
      step(0, '0, 0);
      chk("t5_en", adc_en, 0);
      chk("t5_busy", busy, 0);
      chk("t5_val", sample_valid, 1);
      for (int i = 0; i < P + 4; i++) step(0, '0, 0);
      chk("t5_idle", adc_en, 0);
      sample_ready = 1'b1;
      step(0, '0, 0);
      chk("t5_cons", sample_valid, 0);
      run = 1'b1;
      e0  = cyc + 1;
      nk  = 1;
      frame(7, 12'h5A5, 1, 0);

      // T6: asynchronous reset mid-ARM
      wait_arm();
      step(0, '0, 0);
      #3;
      rst = 1'b0;
      #1;
      chk("t6_en", adc_en, 0);
      chk("t6_out", sample_out, 0);
      chk("t6_val", sample_valid, 0);
      chk("t6_flags", {overrun, timeout, busy}, 0);
      m_valid  = 1'b0;
      m_sample = '0;
      m_ovr    = 1'b0;
      m_to     = 1'b0;
      tick();
      tick();
      rst = 1'b1;
      e0  = cyc + 1;
      nk  = 1;
      frame(17, 12'h123, 1, 1);
      chk("t6_out2", sample_out, fmt(12'h123));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
